tune_sched: RTL and testbench

//  Sequences the piezo tone generator (tone_gen) that drives piezo/piezo_n.

---
 rtl/tune_pkg.sv | 63 ++++++
 rtl/tune_rom.sv | 12 +
 rtl/tune_sched.sv | 123 ++++++++++++
 tb/tb_tune_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tune_pkg.sv
// Shared types and the flat note table for the piezo tune sequencer.
// Tunes sit back to back in NOTES; each tune is addressed by its base and length.
package tune_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, CHARGE = 2'd1, FAULT = 2'd2, DONE = 2'd3} tune_e;

  typedef struct packed {
    logic [14:0] hp;
    logic [24:0] dur;
  } note_t;

  localparam logic [14:0] HP_REST = 15'd0;
  localparam logic [14:0] HP_C6   = 15'd23877;
  localparam logic [14:0] HP_G6   = 15'd15944;
  localparam logic [14:0] HP_C7   = 15'd11944;
  localparam logic [14:0] HP_E7   = 15'd9480;
  localparam logic [14:0] HP_G7   = 15'd7972;

  localparam logic [24:0] D_4M  = 25'h0400000;
  localparam logic [24:0] D_8M  = 25'h0800000;
  localparam logic [24:0] D_12M = 25'h0C00000;
  localparam logic [24:0] D_16M = 25'h1000000;

  localparam int NUM_NOTES = 11;
  localparam note_t NOTES [NUM_NOTES] = '{
    '{HP_G6, D_8M}, '{HP_C7, D_8M}, '{HP_E7, D_8M}, '{HP_G7, D_12M}, '{HP_E7, D_4M}, '{HP_G7, D_16M},
    '{HP_C6, D_4M}, '{HP_REST, D_4M}, '{HP_C6, D_4M},
    '{HP_C7, D_4M}, '{HP_G7, D_8M}
  };

  localparam logic [3:0] BASE_CHARGE = 4'd0, LEN_CHARGE = 4'd6;
  localparam logic [3:0] BASE_FAULT  = 4'd6, LEN_FAULT  = 4'd3;
  localparam logic [3:0] BASE_DONE   = 4'd9, LEN_DONE   = 4'd2;

  // Pending-register bit positions.
  localparam int P_CHARGE = 0, P_FAULT = 1, P_DONE = 2;

  function automatic logic [3:0] tune_base(tune_e t);
    case (t)
      CHARGE:  return BASE_CHARGE;
      FAULT:   return BASE_FAULT;
      DONE:    return BASE_DONE;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] tune_last(tune_e t);
    case (t)
      CHARGE:  return BASE_CHARGE + LEN_CHARGE - 4'd1;
      FAULT:   return BASE_FAULT + LEN_FAULT - 4'd1;
      DONE:    return BASE_DONE + LEN_DONE - 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] tune_bit(tune_e t);
    case (t)
      CHARGE:  return 3'b001;
      FAULT:   return 3'b010;
      DONE:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/tune_rom.sv
// Combinational note lookup into the flat tune table; out-of-range reads return a rest.
module tune_rom
  import tune_pkg::*;
(
  input  logic [3:0] idx,
  output note_t      note
);
  always_comb begin
    note = '0;
    if (idx < 4'(NUM_NOTES)) note = NOTES[idx];
  end
endmodule

// File: rtl/tune_sched.sv
// Piezo tune sequencer: sticky request bits, fixed-priority select, note issue over
// valid/ready, and fault pre-emption through a one-cycle abort to tone_gen.
module tune_sched
  import tune_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_fault,
  input  logic        req_charge,
  input  logic        req_done,
  input  logic        tone_rdy,
  input  logic        tone_done,
  output logic        tone_vld,
  output logic [14:0] half_period,
  output logic [24:0] duration,
  output logic        tone_abort,
  output logic        busy,
  output logic [1:0]  cur_tune
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ABORT} state_e;
  localparam int DUR_SH = FAST_SIM ? 4 : 0;

  state_e      state_q, state_d;
  tune_e       tune_q, tune_d;
  logic [2:0]  pend_q, pend_d;
  logic [3:0]  idx_q, idx_d;
  logic        vld_q, vld_d, abort_q, abort_d, busy_q, busy_d;
  logic [14:0] hp_q, hp_d;
  logic [24:0] dur_q, dur_d;
  logic [2:0]  reqs, clr, ign;
  logic        playing, preempt, finish;
  note_t       note;

  // Outputs are registered, so the ROM is read with the next note index.
  tune_rom u_rom (.idx(idx_d), .note(note));

  always_comb begin
    reqs    = {req_done, req_fault, req_charge};
    playing = (state_q == ISSUE) || (state_q == WAIT);
    preempt = playing && (tune_q != FAULT) && (req_fault || pend_q[P_FAULT]);
    finish  = (state_q == WAIT) && tone_done && (idx_q == tune_last(tune_q)) && !preempt;
    // A re-request on the completion cycle is kept so the tune replays.
    ign     = (playing && !finish) ? tune_bit(tune_q) : 3'b000;
    clr     = 3'b000;
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        tune_d = NONE;
        if (|pend_q) begin
          tune_d  = pend_q[P_FAULT] ? FAULT : (pend_q[P_CHARGE] ? CHARGE : DONE);
          idx_d   = tune_base(tune_d);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (preempt) begin
          clr     = tune_bit(tune_q);
          state_d = ABORT;
        end else if (tone_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (preempt) begin
          clr     = tune_bit(tune_q);
          state_d = ABORT;
        end else if (finish) begin
          clr     = tune_bit(tune_q);
          tune_d  = NONE;
          state_d = IDLE;
        end else if (tone_done) begin
          idx_d   = idx_q + 4'd1;
          state_d = ISSUE;
        end
      end
      default: begin
        tune_d  = NONE;
        state_d = IDLE;
      end
    endcase
    pend_d  = (pend_q & ~clr) | (reqs & ~ign);
    vld_d   = (state_d == ISSUE);
    abort_d = (state_d == ABORT);
    busy_d  = (state_d != IDLE);
    hp_d    = vld_d ? note.hp : 15'd0;
    dur_d   = vld_d ? (note.dur >> DUR_SH) : 25'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tune_q  <= NONE;
      pend_q  <= 3'b000;
      idx_q   <= 4'd0;
      vld_q   <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      hp_q    <= 15'd0;
      dur_q   <= 25'd0;
    end else begin
      state_q <= state_d;
      tune_q  <= tune_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      hp_q    <= hp_d;
      dur_q   <= dur_d;
    end
  end

  assign tone_vld    = vld_q;
  assign tone_abort  = abort_q;
  assign busy        = busy_q;
  assign half_period = hp_q;
  assign duration    = dur_q;
  assign cur_tune    = tune_q;
endmodule

// File: tb/tb_tune_sched.sv
// Directed sequence with randomized handshake timing; expected notes come from the tune tables.
module tb_tune_sched;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        req_fault = 1'b0, req_charge = 1'b0, req_done = 1'b0;
  logic        tone_rdy = 1'b0, tone_done = 1'b0;
  logic        tone_vld, tone_abort, busy;
  logic [14:0] half_period;
  logic [24:0] duration;
  logic [1:0]  cur_tune;
  int          n_tests = 0, n_fail = 0;

  // Tune codes: 0 none, 1 charge, 2 fault, 3 done.
  int c_hp[6] = '{15944, 11944, 9480, 7972, 9480, 7972};
  int c_du[6] = '{1 << 23, 1 << 23, 1 << 23, (1 << 23) + (1 << 22), 1 << 22, 1 << 24};
  int f_hp[3] = '{23877, 0, 23877};
  int f_du[3] = '{1 << 22, 1 << 22, 1 << 22};
  int d_hp[2] = '{11944, 7972};
  int d_du[2] = '{1 << 22, 1 << 23};

  always #5 clk = ~clk;

  tune_sched #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_fault(req_fault), .req_charge(req_charge), .req_done(req_done),
    .tone_rdy(tone_rdy), .tone_done(tone_done), .tone_vld(tone_vld), .half_period(half_period),
    .duration(duration), .tone_abort(tone_abort), .busy(busy), .cur_tune(cur_tune)
  );

  function automatic int tune_len(int t);
    return (t == 1) ? 6 : (t == 2) ? 3 : 2;
  endfunction

  function automatic int ref_hp(int t, int i);
    case (t)
      1:       return c_hp[i];
      2:       return f_hp[i];
      default: return d_hp[i];
    endcase
  endfunction

  function automatic int ref_dur(int t, int i);
    case (t)
      1:       return c_du[i] >> 4;
      2:       return f_du[i] >> 4;
      default: return d_du[i] >> 4;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int t, logic v);
    case (t)
      1:       req_charge = v;
      2:       req_fault  = v;
      default: req_done   = v;
    endcase
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, " vld"}, tone_vld, 0);
    check({tag, " abort"}, tone_abort, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " cur_tune"}, cur_tune, 0);
    check({tag, " hp"}, half_period, 0);
    check({tag, " dur"}, duration, 0);
  endtask

  task automatic wait_vld(string tag);
    for (int n = 0; n < 50 && tone_vld !== 1'b1; n++) tick();
    check(tag, tone_vld, 1);
  endtask

  task automatic idle_window(int n);
    repeat (n) begin
      tick();
      check("idle busy", busy, 0);
      check("idle vld", tone_vld, 0);
    end
  endtask

  // Pulse a request from idle and check the two-cycle offer latency.
  task automatic request(int t);
    set_req(t, 1'b1);
    tick();
    set_req(t, 1'b0);
    check("latency k+1 vld", tone_vld, 0);
    tick();
    check("latency k+2 vld", tone_vld, 1);
  endtask

  task automatic accept(int t, int i, int hold);
    wait_vld($sformatf("t%0d n%0d offer", t, i));
    check($sformatf("t%0d n%0d hp", t, i), half_period, ref_hp(t, i));
    check($sformatf("t%0d n%0d dur", t, i), duration, ref_dur(t, i));
    check("cur_tune", cur_tune, t);
    check("busy", busy, 1);
    repeat (hold) begin
      tick();
      check("hold vld", tone_vld, 1);
      check("hold hp", half_period, ref_hp(t, i));
      check("hold dur", duration, ref_dur(t, i));
    end
    tone_rdy = 1'b1;
    tick();
    tone_rdy = 1'b0;
    check("wait vld", tone_vld, 0);
    check("wait hp", half_period, 0);
  endtask

  task automatic play_note(int t, int i, int hold, bit rq_wait, bit rq_done);
    int gap;
    accept(t, i, hold);
    gap = $urandom_range(1, 8);
    for (int g = 0; g < gap; g++) begin
      if (rq_wait && g == 0) set_req(t, 1'b1);
      tick();
      set_req(t, 1'b0);
    end
    tone_done = 1'b1;
    if (rq_done) set_req(t, 1'b1);
    tick();
    tone_done = 1'b0;
    set_req(t, 1'b0);
  endtask

  task automatic play_tune(int t, int hold0, int rq_note, bit rq_last);
    int len;
    len = tune_len(t);
    for (int i = 0; i < len; i++)
      play_note(t, i, (i == 0) ? hold0 : int'($urandom_range(0, 2)), i == rq_note,
                rq_last && (i == len - 1));
    check("end busy", busy, 0);
    check("end cur_tune", cur_tune, 0);
    check("end vld", tone_vld, 0);
  endtask

  initial begin
    int t;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    idle_window(3);

    // Full charge tune, first offer held off for 20 cycles.
    request(1);
    play_tune(1, 20, -1, 1'b0);
    idle_window(2);

    // Re-request of the playing tune is ignored.
    request(1);
    play_tune(1, 0, 2, 1'b0);
    idle_window(10);

    // Re-request on the completion cycle replays the tune.
    request(3);
    play_tune(3, 0, -1, 1'b1);
    tick();
    check("replay vld", tone_vld, 1);
    play_tune(3, 0, -1, 1'b0);
    idle_window(3);

    // Fault pre-empts charge during its third note.
    request(1);
    play_note(1, 0, 0, 1'b0, 1'b0);
    play_note(1, 1, 1, 1'b0, 1'b0);
    accept(1, 2, 0);
    repeat (3) tick();
    req_fault = 1'b1;
    tick();
    req_fault = 1'b0;
    check("abort pulse", tone_abort, 1);
    check("abort vld", tone_vld, 0);
    check("abort busy", busy, 1);
    check("abort hp", half_period, 0);
    check("abort dur", duration, 0);
    tick();
    check("post-abort pulse", tone_abort, 0);
    check("post-abort busy", busy, 0);
    tick();
    check("fault start vld", tone_vld, 1);
    play_tune(2, 1, -1, 1'b0);
    idle_window(10);

    // Pre-emption wins over the last note's tone_done.
    request(3);
    play_note(3, 0, 0, 1'b0, 1'b0);
    accept(3, 1, 0);
    tick();
    req_fault = 1'b1;
    tone_done = 1'b1;
    tick();
    req_fault = 1'b0;
    tone_done = 1'b0;
    check("abort vs done", tone_abort, 1);
    tick();
    tick();
    play_tune(2, 0, -1, 1'b0);
    idle_window(6);

    // Charge and done requested together: charge first, done one cycle after idle.
    req_charge = 1'b1;
    req_done   = 1'b1;
    tick();
    req_charge = 1'b0;
    req_done   = 1'b0;
    tick();
    check("both charge first", cur_tune, 1);
    play_tune(1, 0, -1, 1'b0);
    tick();
    check("done follows vld", tone_vld, 1);
    play_tune(3, 0, -1, 1'b0);
    idle_window(3);

    // Random single tunes with random handshake timing.
    for (int r = 0; r < 5; r++) begin
      t = $urandom_range(1, 3);
      request(t);
      play_tune(t, $urandom_range(0, 4), -1, 1'b0);
      idle_window(2);
    end

    // Asynchronous reset mid-WAIT with another tune pending.
    request(3);
    accept(3, 0, 0);
    req_charge = 1'b1;
    tick();
    req_charge = 1'b0;
    tick();
    rst_n = 1'b0;
    #2 check_reset_outputs("async reset");
    @(negedge clk) rst_n = 1'b1;
    idle_window(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
